// File: rtl/hazard_control_if.sv
// Bundle of hazard inputs from the pipeline latches and the latch/PC control outputs.
// slave = hazard_control_unit side, master = pipeline (or bench) side.
interface hazard_control_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  // No valid/ready pairs here: every enable/flush is a same-cycle command that
  // the pipeline applies at the next clock edge; an enable of 0 holds the latch.
  logic             ihit;
  logic             dhit;
  logic             em_dren;
  logic             em_dwen;
  logic             em_branch_taken;
  logic             de_memread;
  logic             de_regwrite;
  logic [REG_W-1:0] de_wsel;
  logic             em_regwrite;
  logic [REG_W-1:0] em_wsel;
  logic             mw_regwrite;
  logic [REG_W-1:0] mw_wsel;
  logic [REG_W-1:0] fd_rs;
  logic [REG_W-1:0] fd_rt;
  logic             mw_halt;

  logic             pc_en;
  logic             fdif_en;
  logic             fdif_flush;
  logic             deif_en;
  logic             deif_flush;
  logic             emif_en;
  logic             emif_flush;
  logic             mwif_en;
  logic             halt;
  logic [CNT_W-1:0] stall_cnt;
  logic             mem_timeout;

  modport slave (
    input  ihit, dhit, em_dren, em_dwen, em_branch_taken, de_memread, de_regwrite,
           de_wsel, em_regwrite, em_wsel, mw_regwrite, mw_wsel, fd_rs, fd_rt, mw_halt,
    output pc_en, fdif_en, fdif_flush, deif_en, deif_flush, emif_en, emif_flush,
           mwif_en, halt, stall_cnt, mem_timeout
  );

  modport master (
    output ihit, dhit, em_dren, em_dwen, em_branch_taken, de_memread, de_regwrite,
           de_wsel, em_regwrite, em_wsel, mw_regwrite, mw_wsel, fd_rs, fd_rt, mw_halt,
    input  pc_en, fdif_en, fdif_flush, deif_en, deif_flush, emif_en, emif_flush,
           mwif_en, halt, stall_cnt, mem_timeout
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer for the 5-stage core: latch enables/flushes, PC enable, halt and debug counters.
// Optional macro FORWARDING_EN: when defined only load-use stalls; otherwise every RAW hazard stalls.
module hazard_control_unit #(
  parameter int REG_W     = 5,
  parameter int CNT_W     = 32,
  parameter int DWAIT_MAX = 255
) (
  input  logic             CLK,
  input  logic             nRST,
  hazard_control_if.slave  hz,
  output logic [1:0]       dbg_state_o
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] DWAIT   = 2'd1;
  localparam logic [1:0] LDSTALL = 2'd2;
  localparam logic [1:0] HALT    = 2'd3;

  localparam int              WAIT_W   = (DWAIT_MAX < 2) ? 1 : $clog2(DWAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(DWAIT_MAX);

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              halt_q, halt_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q;

  logic en_pc, en_fd, fl_fd, en_de, fl_de, en_em, fl_em, en_mw;
  logic dpend, load_use, hazard;

  // Register index 0 is hardwired, so a write to it never creates a dependence.
  function automatic logic src_match(input logic [REG_W-1:0] dst,
                                     input logic [REG_W-1:0] rs,
                                     input logic [REG_W-1:0] rt);
    return (dst != '0) && ((dst == rs) || (dst == rt));
  endfunction

  assign dpend    = (hz.em_dren | hz.em_dwen) & ~hz.dhit;
  assign load_use = hz.de_memread & hz.de_regwrite & src_match(hz.de_wsel, hz.fd_rs, hz.fd_rt);

`ifdef FORWARDING_EN
  assign hazard = load_use;
`else
  assign hazard = load_use
                | (hz.de_regwrite & src_match(hz.de_wsel, hz.fd_rs, hz.fd_rt))
                | (hz.em_regwrite & src_match(hz.em_wsel, hz.fd_rs, hz.fd_rt))
                | (hz.mw_regwrite & src_match(hz.mw_wsel, hz.fd_rs, hz.fd_rt));
`endif

  // RUN, DWAIT (once dhit arrives) and LDSTALL share one priority chain;
  // only the wait counter continuation depends on the current state.
  always_comb begin
    en_pc     = 1'b1;
    en_fd     = 1'b1;
    fl_fd     = 1'b0;
    en_de     = 1'b1;
    fl_de     = 1'b0;
    en_em     = 1'b1;
    fl_em     = 1'b0;
    en_mw     = 1'b1;
    state_d   = RUN;
    wait_d    = '0;
    halt_d    = halt_q;
    timeout_d = timeout_q;

    if (state_q == HALT || hz.mw_halt) begin
      {en_pc, en_fd, en_de, en_em, en_mw} = '0;
      state_d = HALT;
      halt_d  = 1'b1;
    end else if (dpend) begin
      {en_pc, en_fd, en_de, en_em, en_mw} = '0;
      state_d = DWAIT;
      if (state_q != DWAIT)     wait_d = WAIT_W'(1);
      else if (wait_q == WAIT_MAX) wait_d = wait_q;
      else                      wait_d = wait_q + WAIT_W'(1);
      if (wait_d == WAIT_MAX) timeout_d = 1'b1;
    end else if (hz.em_branch_taken) begin
      fl_fd = 1'b1;
      fl_de = 1'b1;
      fl_em = 1'b1;
    end else if (hazard) begin
      en_pc   = 1'b0;
      en_fd   = 1'b0;
      fl_de   = 1'b1;
      state_d = LDSTALL;
    end else if (!hz.ihit) begin
      en_pc = 1'b0;
      fl_fd = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= RUN;
      wait_q      <= '0;
      halt_q      <= 1'b0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      halt_q    <= halt_d;
      timeout_q <= timeout_d;
      if (state_q != HALT && !en_pc && !(&stall_cnt_q))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  // Held in reset, the pipeline must see every latch frozen.
  assign hz.pc_en       = nRST & en_pc;
  assign hz.fdif_en     = nRST & en_fd;
  assign hz.fdif_flush  = nRST & fl_fd;
  assign hz.deif_en     = nRST & en_de;
  assign hz.deif_flush  = nRST & fl_de;
  assign hz.emif_en     = nRST & en_em;
  assign hz.emif_flush  = nRST & fl_em;
  assign hz.mwif_en     = nRST & en_mw;
  assign hz.halt        = halt_q;
  assign hz.stall_cnt   = stall_cnt_q;
  assign hz.mem_timeout = timeout_q;
  assign dbg_state_o    = state_q;

endmodule
